sram_like_responder: RTL and testbench
======================================

SRAM_LIKE_RESPONDER -- requirements
Module: sram_like_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 4: maximum outstanding requests; power of two, 2..16.
REQ-002 SHALL have parameter LATENCY, default 2: minimum cycles from acceptance to data_ok; legal range 1..15.
REQ-003 SHALL have parameter MEM_AW, default 16: word-address width of the internal backing store (2^MEM_AW 32-bit words).
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req  input  1  initiator request valid.
REQ-007 SHALL have port wr  input  1  1 = write, 0 = read.
REQ-008 SHALL have port size  input  2  transfer size (0 byte, 1 half, 2 word); recorded only; 3 treated as 2.
REQ-009 SHALL have port wstrb  input  4  byte write enables, meaningful when wr=1.
REQ-010 SHALL have port addr  input  32  byte address; word index is addr[MEM_AW+1:2].
REQ-011 SHALL have port wdata  input  32  write data.
REQ-012 SHALL have port addr_ok  output  1  request accepted this cycle when req & addr_ok.
REQ-013 SHALL have port data_ok  output  1  one response completes this cycle.
REQ-014 SHALL have port rdata  output  32  read data, valid with data_ok for reads; 0 for write responses.

Function
REQ-015 Acceptance SHALL occur only on a cycle with req=1 and addr_ok=1; no other input is sampled.
REQ-016 addr_ok SHALL depend only on registered state (outstanding count, gating register), never combinationally on req or data_ok.
REQ-017 addr_ok SHALL be 0 whenever outstanding count equals DEPTH, even if a response retires that cycle.
REQ-018 An accepted write SHALL update the backing store on the acceptance edge, each byte i gated by wstrb[i]; wstrb=0 SHALL update nothing but still return data_ok.
REQ-019 An accepted read SHALL capture the word at its index on the acceptance edge, so a read accepted after a write to the same word returns the new data.
REQ-020 Each accepted request SHALL enter an in-order queue entry holding {wr, captured rdata, countdown initialised to LATENCY-1}.
REQ-021 Every valid entry's countdown SHALL decrement by 1 per cycle, saturating at 0.
REQ-022 data_ok SHALL be 1 exactly when the head entry is valid and its countdown is 0; that entry retires on the same edge.
REQ-023 Request accepted at edge T SHALL produce data_ok no earlier than the cycle following edge T+LATENCY-1, i.e. LATENCY cycles after the accept cycle.
REQ-024 Responses SHALL return strictly in acceptance order, at most one per cycle; back-to-back accepts SHALL yield back-to-back data_ok.
REQ-025 Simultaneous accept and retire SHALL leave the outstanding count unchanged; queue pointers SHALL wrap modulo DEPTH.
REQ-026 When empty, data_ok SHALL be 0 and rdata SHALL be 0.

Reset
REQ-027 On resetn=0, asynchronously: queue emptied, pointers and count 0, data_ok=0, rdata=0, addr_ok=1.
REQ-028 Reset mid-operation SHALL discard all outstanding requests with no data_ok emitted; backing-store contents SHALL be retained (not reset).
REQ-029 First acceptance possible in the first cycle after resetn rises.

Configuration
REQ-030 Macro SRAM_LIKE_BACKPRESSURE_EN: when defined, an 8-bit Fibonacci LFSR (taps 8,6,5,4, reset seed 8'hA5) advances every cycle and addr_ok = ~full & lfsr[0]; when undefined, no LFSR exists and addr_ok = ~full.
REQ-031 With the macro defined, the LFSR SHALL reset asynchronously to 8'hA5, so addr_ok=1 in reset.

Verification
REQ-032 Defaults, write addr 0x10 wdata 0xDEADBEEF wstrb 4'hF, then read 0x10 next cycle -> two data_ok two cycles after each accept; read rdata 0xDEADBEEF, write rdata 0.
REQ-033 Preload 0x11223344 at 0x20, write wstrb 4'b0101 wdata 0xAABBCCDD, read 0x20 -> rdata 0x11BB33DD.
REQ-034 req held high 10 cycles, reads to 0x0..0x24, DEPTH=4, LATENCY=2 -> addr_ok never drops (two outstanding max); data_ok continuous, in address order.
REQ-035 LATENCY=8, req held high -> addr_ok falls after 4 accepts, rises one cycle after first data_ok; count never exceeds 4.
REQ-036 3 reads outstanding, resetn pulsed low mid-cycle -> data_ok, rdata 0 immediately; no stale data_ok after release; earlier written data still readable.
REQ-037 SRAM_LIKE_BACKPRESSURE_EN defined, req held high 64 cycles -> accepts only on lfsr[0]=1 cycles, responses still in order with no loss.

Source files
------------

// File: rtl/sram_like_responder.sv
// sram_like_responder
//   SRAM-style slave: a word-addressed backing store behind an in-order
//   request queue. Requests are accepted on req & addr_ok; each one answers
//   with a single data_ok pulse LATENCY cycles after its accept cycle, in
//   acceptance order, at most one per cycle.
//
//   Parameters: DEPTH (max outstanding, power of two 2..16),
//               LATENCY (1..15), MEM_AW (word-address width of the store).
//   Ports:  clk, resetn (async, active low)
//           req, wr, size[1:0], wstrb[3:0], addr[31:0], wdata[31:0]  (in)
//           addr_ok, data_ok, rdata[31:0]                            (out)
//   Optional: `define SRAM_LIKE_BACKPRESSURE_EN gates addr_ok with bit 0 of
//   an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5).
//   The backing store is deliberately not reset; its contents survive resetn.
module sram_like_responder #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2,
    parameter int MEM_AW  = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);
    localparam int         PW       = $clog2(DEPTH);
    localparam int         CW       = PW + 1;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [PW-1:0]              head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]              count_q, count_d;
    logic [DEPTH-1:0]           vld_q, vld_d, wr_q, wr_d;
    logic [DEPTH-1:0][31:0]     data_q, data_d;
    logic [DEPTH-1:0][3:0]      cnt_q, cnt_d;
    logic [DEPTH-1:0][1:0]      size_q, size_d;

    logic [31:0] mem_q [0:(1<<MEM_AW)-1];

    logic [MEM_AW-1:0] idx;
    logic              full, accept, retire;

    assign idx    = addr[MEM_AW+1:2];
    assign full   = (count_q == CW'(DEPTH));
    assign accept = req & addr_ok;
    assign retire = data_ok;

`ifdef SRAM_LIKE_BACKPRESSURE_EN
    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr_q <= 8'hA5;
        else         lfsr_q <= lfsr_d;
    end

    assign addr_ok = ~full & lfsr_q[0];
`else
    assign addr_ok = ~full;
`endif

    // Head entry answers once its countdown has run out.
    assign data_ok = vld_q[head_q] && (cnt_q[head_q] == 4'd0);
    assign rdata   = (data_ok && !wr_q[head_q]) ? data_q[head_q] : 32'd0;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        vld_d   = vld_q;
        wr_d    = wr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        count_d = count_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && cnt_q[i] != 4'd0) cnt_d[i] = cnt_q[i] - 4'd1;
        end

        if (retire) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + 1'b1;
        end

        // Tail never collides with a retiring head: accept is blocked when full.
        if (accept) begin
            vld_d[tail_q]  = 1'b1;
            wr_d[tail_q]   = wr;
            data_d[tail_q] = mem_q[idx];
            cnt_d[tail_q]  = CNT_INIT;
            size_d[tail_q] = (size == 2'd3) ? 2'd2 : size;
            tail_d         = tail_q + 1'b1;
        end

        case ({accept, retire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
            wr_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
        end
    end

    // Byte-gated write on the acceptance edge.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (accept && wr && wstrb[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    // Address bits outside the word index and the recorded size are not consumed.
    logic unused_ok;
    assign unused_ok = ^{addr[31:MEM_AW+2], addr[1:0], size_q};

endmodule

// File: tb/tb_sram_like_responder.sv
module tb_sram_like_responder;
    localparam int DEPTH = 4;
    localparam int LAT0  = 2;
    localparam int LAT1  = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req, wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;
    logic [1:0]  aok, dok;
    logic [31:0] rd [2];

    always #5 clk = ~clk;

    sram_like_responder #(.DEPTH(DEPTH), .LATENCY(LAT0), .MEM_AW(16)) u_dut0 (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(aok[0]), .data_ok(dok[0]), .rdata(rd[0]));

    sram_like_responder #(.DEPTH(DEPTH), .LATENCY(LAT1), .MEM_AW(16)) u_dut1 (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(aok[1]), .data_ok(dok[1]), .rdata(rd[1]));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference model: per instance, a word store and a list of pending
    // responses, each due exactly LATENCY cycles after its accept cycle.
    logic [31:0] mmem [2][64];
    int          mdue [2][$];
    logic [31:0] mrd  [2][$];
    int          cyc = 0;
    logic [1:0]  acc_seen = '0;
`ifdef SRAM_LIKE_BACKPRESSURE_EN
    logic [7:0]  lf = 8'hA5;
`endif

    always @(negedge clk) begin
        int          lat_k, widx;
        logic        e_aok, e_dok;
        logic [31:0] e_rd;
        if (!resetn) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("rst_addr_ok%0d", k), aok[k], 1);
                chk($sformatf("rst_data_ok%0d", k), dok[k], 0);
                chk($sformatf("rst_rdata%0d", k), rd[k], 0);
                mdue[k].delete();
                mrd[k].delete();
            end
`ifdef SRAM_LIKE_BACKPRESSURE_EN
            lf = 8'hA5;
`endif
        end else begin
            for (int k = 0; k < 2; k++) begin
                lat_k = (k == 0) ? LAT0 : LAT1;
                e_aok = (mdue[k].size() < DEPTH);
`ifdef SRAM_LIKE_BACKPRESSURE_EN
                e_aok = e_aok & lf[0];
`endif
                e_dok = (mdue[k].size() > 0) && (mdue[k][0] == cyc);
                e_rd  = e_dok ? mrd[k][0] : 32'd0;
                chk($sformatf("addr_ok%0d@%0d", k, cyc), aok[k], e_aok);
                chk($sformatf("data_ok%0d@%0d", k, cyc), dok[k], e_dok);
                chk($sformatf("rdata%0d@%0d", k, cyc), rd[k], e_rd);
                if (e_dok) begin
                    void'(mdue[k].pop_front());
                    void'(mrd[k].pop_front());
                end
                if (req && e_aok) begin
                    widx = int'(addr[7:2]);
                    if (wr) begin
                        for (int b = 0; b < 4; b++)
                            if (wstrb[b]) mmem[k][widx][8*b +: 8] = wdata[8*b +: 8];
                        mrd[k].push_back(32'd0);
                    end else begin
                        mrd[k].push_back(mmem[k][widx]);
                    end
                    mdue[k].push_back(cyc + lat_k);
                    acc_seen[k] = 1'b1;
                end
            end
            cyc++;
`ifdef SRAM_LIKE_BACKPRESSURE_EN
            lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
`endif
        end
    end

    // Holds the request until both instances have taken it at least once.
    task automatic issue(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        req = 1'b1; wr = w; wstrb = s; addr = a; wdata = d;
        size = 2'($urandom_range(0, 3));
        acc_seen = '0;
        do begin
            @(posedge clk);
            n++;
        end while (acc_seen != 2'b11 && n < 64);
        chk("accepted_both", acc_seen, 2'b11);
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; req = 1'b0; wr = 1'b0; size = '0; wstrb = '0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        for (int i = 0; i < 64; i++) issue(1'b1, 4'hF, 32'(i * 4), $urandom);
        idle(10);

        issue(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 4'h0, 32'h10, 32'h0);
        idle(12);

        issue(1'b1, 4'hF, 32'h20, 32'h11223344);
        issue(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
        issue(1'b0, 4'h0, 32'h20, 32'h0);
        idle(12);

        issue(1'b1, 4'h0, 32'h30, 32'hFFFFFFFF);
        issue(1'b0, 4'h0, 32'h30, 32'h0);
        idle(12);

        for (int i = 0; i < 10; i++) issue(1'b0, 4'h0, 32'(i * 4), 32'h0);
        idle(12);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  32'($urandom_range(0, 255)), $urandom);
        end
        idle(12);

        issue(1'b0, 4'h0, 32'h04, 32'h0);
        issue(1'b0, 4'h0, 32'h08, 32'h0);
        issue(1'b0, 4'h0, 32'h0C, 32'h0);
        req = 1'b0;
        #2 resetn = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("midrst_data_ok%0d", k), dok[k], 0);
            chk($sformatf("midrst_rdata%0d", k), rd[k], 0);
            chk($sformatf("midrst_addr_ok%0d", k), aok[k], 1);
        end
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;
        issue(1'b0, 4'h0, 32'h10, 32'h0);
        issue(1'b0, 4'h0, 32'h20, 32'h0);
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
